// File: rtl/soc_evt_pkg.sv
// Shared sizing, types and one-hot helpers for the SoC-side event token ring.
package soc_evt_pkg;

  localparam int BUFFER_WIDTH = 8;
  localparam int EVNT_WIDTH   = 8;
  localparam int SYNC_STAGES  = 2;
  localparam int IDX_W        = $clog2(BUFFER_WIDTH);
  localparam int FILL_W       = $clog2(BUFFER_WIDTH) + 1;

  typedef logic [BUFFER_WIDTH-1:0] token_t;
  typedef logic [EVNT_WIDTH-1:0]   evt_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [FILL_W-1:0]       fill_t;

  // OR of the positions of all set bits; exact for a one-hot input.
  function automatic idx_t onehot2idx(input token_t oh);
    idx_t idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      idx = idx | (oh[i] ? idx_t'(i) : {IDX_W{1'b0}});
    end
    return idx;
  endfunction

  function automatic token_t rotl1(input token_t t);
    return {t[BUFFER_WIDTH-2:0], t[BUFFER_WIDTH-1]};
  endfunction

endpackage

// File: rtl/soc_event_token_tx_if.sv
// Producer handshake plus the cluster-side token/pointer/data bus of the event ring.
interface soc_event_token_tx_if;
  import soc_evt_pkg::*;

  logic   evt_valid_i;
  logic   evt_ready_o;
  evt_t   evt_data_i;
  token_t events_wt_o;
  token_t events_rp_i;
  evt_t   events_da_o;
  fill_t  fill_o;
  logic   rp_err_o;

  modport master (
    output evt_valid_i, evt_data_i, events_rp_i,
    input  evt_ready_o, events_wt_o, events_da_o, fill_o, rp_err_o
  );

  modport slave (
    input  evt_valid_i, evt_data_i, events_rp_i,
    output evt_ready_o, events_wt_o, events_da_o, fill_o, rp_err_o
  );

endinterface

// File: rtl/soc_evt_rp_sync.sv
// Per-bit multi-flop synchronizer for the consumer's one-hot read pointer.
module soc_evt_rp_sync
  import soc_evt_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  token_t rp_async_i,
  output token_t rp_sync_o
);

  token_t stage_r [SYNC_STAGES];

  // Shift chain; resets to slot 0 so the ring reads as empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= token_t'(1);
      end
    end else begin
      stage_r[0] <= rp_async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign rp_sync_o = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/soc_event_token_tx.sv
// Producer half of the token-ring event FIFO: stores SoC events and advertises a one-hot write token.
module soc_event_token_tx
  import soc_evt_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  soc_event_token_tx_if.slave  bus
);

  token_t wt_r;
  evt_t   buf_r [BUFFER_WIDTH];
  fill_t  fill_r;
  logic   rp_err_r;

  token_t rp_sync_s;
  logic   full_s;
  logic   ready_s;
  logic   write_s;
  idx_t   wt_idx_s;
  idx_t   rp_idx_s;
  fill_t  fill_next_s;

  soc_evt_rp_sync u_rp_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rp_async_i (bus.events_rp_i),
    .rp_sync_o  (rp_sync_s)
  );

  // Full/ready/occupancy decode; ready depends on registers only.
  always_comb begin
    full_s      = 1'b0;
    ready_s     = 1'b0;
    write_s     = 1'b0;
    wt_idx_s    = onehot2idx(wt_r);
    rp_idx_s    = onehot2idx(rp_sync_s);
    fill_next_s = {FILL_W{1'b0}};
    full_s      = (rotl1(wt_r) == rp_sync_s);
    ready_s     = !full_s && !rp_err_r;
    write_s     = bus.evt_valid_i && ready_s;
    if (wt_idx_s >= rp_idx_s) begin
      fill_next_s = FILL_W'(wt_idx_s) - FILL_W'(rp_idx_s);
    end else begin
      fill_next_s = FILL_W'(wt_idx_s) + FILL_W'(BUFFER_WIDTH) - FILL_W'(rp_idx_s);
    end
  end

  // Ring storage, write token, occupancy and sticky pointer-error state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wt_r     <= token_t'(1);
      fill_r   <= {FILL_W{1'b0}};
      rp_err_r <= 1'b0;
      for (int i = 0; i < BUFFER_WIDTH; i++) begin
        buf_r[i] <= {EVNT_WIDTH{1'b0}};
      end
    end else begin
      if (write_s) begin
        buf_r[wt_idx_s] <= bus.evt_data_i;
        wt_r            <= rotl1(wt_r);
      end else begin
        wt_r <= wt_r;
      end
      fill_r <= fill_next_s;
      if ($countones(rp_sync_s) != 32'sd1) begin
        rp_err_r <= 1'b1;
      end else begin
        rp_err_r <= rp_err_r;
      end
    end
  end

  assign bus.evt_ready_o = ready_s;
  assign bus.events_wt_o = wt_r;
  assign bus.fill_o      = fill_r;
  assign bus.rp_err_o    = rp_err_r;
  // Consumer-domain mux: indexed by the raw pointer, not the synchronized copy.
  assign bus.events_da_o = buf_r[onehot2idx(bus.events_rp_i)];

endmodule

// File: tb/tb_soc_event_token_tx.sv
// Randomized + directed bench for soc_event_token_tx against an index-level ring model.
module tb_soc_event_token_tx;
  import soc_evt_pkg::*;

  localparam int N_STRESS = 10000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  soc_event_token_tx_if bus ();

  soc_event_token_tx dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slot contents, write index, delayed pointer history.
  logic [EVNT_WIDTH-1:0]   m_mem [BUFFER_WIDTH];
  logic [BUFFER_WIDTH-1:0] m_hist [SYNC_STAGES];
  logic [EVNT_WIDTH-1:0]   m_q [$];
  int  m_wp;
  int  m_fill;
  bit  m_fill_known;
  bit  m_err;
  int  m_prod;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [BUFFER_WIDTH-1:0] v);
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [BUFFER_WIDTH-1:0] tok(input int i);
    logic [BUFFER_WIDTH-1:0] one;
    one = 1;
    return one << (i % BUFFER_WIDTH);
  endfunction

  function automatic bit model_ready();
    return !m_err && (tok(m_wp + 1) != m_hist[SYNC_STAGES-1]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BUFFER_WIDTH; i++) m_mem[i] = '0;
    for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = tok(0);
    m_q.delete();
    m_wp = 0;
    m_fill = 0;
    m_fill_known = 1'b1;
    m_err = 1'b0;
  endtask

  task automatic compare_all();
    check_val("wt", bus.events_wt_o, tok(m_wp));
    check_val("ready", bus.evt_ready_o, model_ready());
    check_val("rp_err", bus.rp_err_o, m_err);
    if (m_fill_known) check_val("fill", bus.fill_o, m_fill);
    if ($countones(bus.events_rp_i) == 1)
      check_val("da", bus.events_da_o, m_mem[idx_of(bus.events_rp_i)]);
  endtask

  // One clock: update the model with what the DUT sampled, then compare outputs.
  task automatic step();
    bit acc;
    logic [EVNT_WIDTH-1:0]   d;
    logic [BUFFER_WIDTH-1:0] rp_now;
    logic [BUFFER_WIDTH-1:0] last;
    acc    = bus.evt_valid_i && model_ready();
    d      = bus.evt_data_i;
    rp_now = bus.events_rp_i;
    @(posedge clk_i);
    if (rst_i) begin
      model_reset();
    end else begin
      last = m_hist[SYNC_STAGES-1];
      if ($countones(last) == 1) m_fill = (m_wp - idx_of(last) + BUFFER_WIDTH) % BUFFER_WIDTH;
      else begin
        m_fill_known = 1'b0;
        m_err = 1'b1;
      end
      if (acc) begin
        m_mem[m_wp] = d;
        m_wp = (m_wp + 1) % BUFFER_WIDTH;
        m_q.push_back(d);
        m_prod++;
      end
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = rp_now;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus.evt_valid_i = 1'b0;
    bus.events_rp_i = 8'h01;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    int cons_idx;
    int consumed;
    int cyc;
    bit got;
    bus.evt_valid_i = 1'b0;
    bus.evt_data_i  = 8'h00;
    bus.events_rp_i = 8'h01;
    m_prod = 0;
    model_reset();

    // Reset values
    do_reset();
    check_val("rst_wt", bus.events_wt_o, 8'h01);
    check_val("rst_ready", bus.evt_ready_o, 1'b1);
    check_val("rst_fill", bus.fill_o, 0);
    check_val("rst_err", bus.rp_err_o, 1'b0);
    check_val("rst_da", bus.events_da_o, 8'h00);

    // Three back-to-back writes, then consumer advances to slot 1
    bus.evt_valid_i = 1'b1;
    bus.evt_data_i = 8'hA1; step();
    bus.evt_data_i = 8'hA2; step();
    bus.evt_data_i = 8'hA3; step();
    bus.evt_valid_i = 1'b0;
    step();
    check_val("t2_wt", bus.events_wt_o, 8'h08);
    check_val("t2_fill3", bus.fill_o, 3);
    bus.events_rp_i = 8'h02;
    #1;
    check_val("t2_da_now", bus.events_da_o, 8'hA2);
    for (int i = 0; i < SYNC_STAGES + 1; i++) step();
    check_val("t2_fill2", bus.fill_o, 2);

    // Fill to capacity and hold an extra event
    do_reset();
    bus.evt_valid_i = 1'b1;
    for (int i = 0; i < BUFFER_WIDTH - 1; i++) begin
      bus.evt_data_i = 8'h10 + 8'(i);
      step();
    end
    check_val("t3_wt_full", bus.events_wt_o, 8'h80);
    check_val("t3_ready_full", bus.evt_ready_o, 1'b0);
    bus.evt_data_i = 8'hEE;
    for (int i = 0; i < 10; i++) step();
    check_val("t3_wt_held", bus.events_wt_o, 8'h80);
    bus.evt_valid_i = 1'b0;
    bus.events_rp_i = 8'h80;
    #1;
    check_val("t3_slot7_clean", bus.events_da_o, 8'h00);

    // Wrap: ready returns, write lands in slot 7, token wraps to slot 0
    got = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1 && !got; i++) begin
      step();
      got = bus.evt_ready_o;
    end
    check_val("t4_ready_back", bus.evt_ready_o, 1'b1);
    bus.evt_valid_i = 1'b1;
    bus.evt_data_i = 8'hB7;
    step();
    bus.evt_valid_i = 1'b0;
    check_val("t4_wt_wrap", bus.events_wt_o, 8'h01);
    step();
    check_val("t4_da_slot7", bus.events_da_o, 8'hB7);

    // Malformed read pointer sets a sticky error
    do_reset();
    bus.events_rp_i = 8'h03;
    for (int i = 0; i < SYNC_STAGES; i++) step();
    bus.events_rp_i = 8'h01;
    for (int i = 0; i < SYNC_STAGES; i++) step();
    check_val("t5_err_set", bus.rp_err_o, 1'b1);
    check_val("t5_ready_blocked", bus.evt_ready_o, 1'b0);
    bus.evt_valid_i = 1'b1;
    bus.evt_data_i = 8'h5A;
    for (int i = 0; i < 5; i++) step();
    bus.evt_valid_i = 1'b0;
    check_val("t5_err_sticky", bus.rp_err_o, 1'b1);
    check_val("t5_no_write", bus.events_wt_o, 8'h01);
    do_reset();
    check_val("t5_err_cleared", bus.rp_err_o, 1'b0);

    // Random stress with a consumer that reads whenever it sees data
    m_prod = 0;
    cons_idx = 0;
    consumed = 0;
    cyc = 0;
    while (consumed < N_STRESS && cyc < 80000) begin
      bus.evt_valid_i = (m_prod < N_STRESS) && ($urandom_range(3) != 0);
      bus.evt_data_i  = 8'($urandom);
      step();
      cyc++;
      if (cons_idx != m_wp && $urandom_range(3) != 0 && m_q.size() > 0) begin
        check_val("stress_order", bus.events_da_o, m_q.pop_front());
        consumed++;
        cons_idx = (cons_idx + 1) % BUFFER_WIDTH;
        bus.events_rp_i = tok(cons_idx);
      end
    end
    bus.evt_valid_i = 1'b0;
    check_val("stress_consumed", consumed, N_STRESS);
    check_val("stress_produced", m_prod, N_STRESS);
    check_val("stress_drained", m_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
